// File: rtl/pad_cfg_pkg.sv
// Shared types, register map and defaults for the pad configuration register block.
package pad_cfg_pkg;

  typedef logic [5:0] pad_cfg_t;

  typedef enum logic {
    SEQ_IDLE   = 1'b0,
    SEQ_COMMIT = 1'b1
  } seq_state_e;

  localparam int unsigned PAD_CFG_NUM_PADS      = 48;
  localparam int unsigned PAD_CFG_PADS_PER_STEP = 8;

  localparam logic [11:0] PAD_CFG_SHADOW_BASE = 12'h000;
  localparam logic [11:0] PAD_CFG_CTRL_OFFS   = 12'h030;

  localparam int unsigned CTRL_COMMIT_BIT = 0;
  localparam int unsigned CTRL_BUSY_BIT   = 1;
  localparam int unsigned CTRL_LOCK_BIT   = 2;

  // Four pads per 32-bit word, one per byte, upper two bits of each byte read as zero.
  function automatic logic [31:0] pack_word(input pad_cfg_t b0, input pad_cfg_t b1,
                                            input pad_cfg_t b2, input pad_cfg_t b3);
    return {2'b00, b3, 2'b00, b2, 2'b00, b1, 2'b00, b0};
  endfunction

endpackage

// File: rtl/pad_cfg_commit_seq.sv
// Commit sequencer: walks the pad groups one per cycle and flags busy/done.
module pad_cfg_commit_seq
  import pad_cfg_pkg::*;
#(
  parameter int NUM_STEPS = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic [NUM_STEPS-1:0] grp_en_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  seq_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEQ_IDLE;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    done_d  = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (start_i) begin
          state_d = SEQ_COMMIT;
          step_d  = '0;
        end
      end
      SEQ_COMMIT: begin
        if (step_q == LAST_STEP) begin
          state_d = SEQ_IDLE;
          step_d  = '0;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STEPS; gi++) begin : g_grp
      assign grp_en_o[gi] = (state_q == SEQ_COMMIT) && (step_q == STEP_W'(gi));
    end
  endgenerate

  assign busy_o = (state_q == SEQ_COMMIT);
  assign done_o = done_q;

endmodule

// File: rtl/pad_cfg_regs.sv
// APB-lite shadow/active pad configuration registers with staggered commit.
// Optional write lock (CTRL.LOCK) is built only when PAD_CFG_LOCK_EN is defined.
module pad_cfg_regs
  import pad_cfg_pkg::*;
#(
  parameter int NUM_PADS      = PAD_CFG_NUM_PADS,
  parameter int PADS_PER_STEP = PAD_CFG_PADS_PER_STEP
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [11:0]               paddr_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic [NUM_PADS-1:0][5:0]  pad_cfg_o,
  output logic                      busy_o,
  output logic                      commit_done_o
);

  localparam int NUM_WORDS  = NUM_PADS / 4;
  localparam int NUM_STEPS  = NUM_PADS / PADS_PER_STEP;
  localparam int WORD_IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  pad_cfg_t                 shadow_q [NUM_PADS];
  pad_cfg_t                 shadow_d [NUM_PADS];
  logic [NUM_PADS-1:0][5:0] active_q, active_d;
  logic [31:0]              word_data [NUM_WORDS];

  logic [11:0]              offs;
  logic [WORD_IDX_W-1:0]    word_sel;
  logic                     access, is_ctrl, is_shadow, addr_ok, stall;
  logic                     lock_q, lock_err;
  logic                     wr_en, shadow_wr, commit_start, busy;
  logic [NUM_STEPS-1:0]     grp_en;
  logic                     unused_pwdata;

  assign access    = psel_i & penable_i;
  assign offs      = paddr_i - PAD_CFG_SHADOW_BASE;
  assign word_sel  = offs[2 +: WORD_IDX_W];
  assign is_ctrl   = (paddr_i == PAD_CFG_CTRL_OFFS);
  assign is_shadow = !is_ctrl && (offs[1:0] == 2'b00) &&
                     ({2'b00, offs[11:2]} < 12'(NUM_WORDS));
  assign addr_ok   = is_ctrl | is_shadow;

  // Any write waits out an active commit so shadow edits can never tear it.
  assign stall     = access & pwrite_i & busy;
  assign pready_o  = access & ~stall;
  assign pslverr_o = pready_o & (~addr_ok | lock_err);

  assign wr_en        = pready_o & pwrite_i & addr_ok & ~lock_err;
  assign shadow_wr    = wr_en & is_shadow;
  assign commit_start = wr_en & is_ctrl & pwdata_i[CTRL_COMMIT_BIT];

`ifdef PAD_CFG_LOCK_EN
  logic lock_d;
  assign lock_d   = lock_q | (wr_en & is_ctrl & pwdata_i[CTRL_LOCK_BIT]);
  assign lock_err = lock_q & pwrite_i & (is_shadow | (is_ctrl & pwdata_i[CTRL_COMMIT_BIT]));

  always_ff @(posedge clk_i) begin
    if (rst_i) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end
`else
  assign lock_q   = 1'b0;
  assign lock_err = 1'b0;
`endif

  always_comb begin
    prdata_o = '0;
    if (pready_o && !pwrite_i) begin
      if (is_ctrl) begin
        prdata_o[CTRL_BUSY_BIT] = busy;
        prdata_o[CTRL_LOCK_BIT] = lock_q;
      end else if (is_shadow) begin
        prdata_o = word_data[word_sel];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign word_data[gi] = pack_word(shadow_q[4*gi], shadow_q[4*gi+1],
                                       shadow_q[4*gi+2], shadow_q[4*gi+3]);
    end
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      assign shadow_d[gi] = (shadow_wr && (word_sel == WORD_IDX_W'(gi / 4)))
                            ? pwdata_i[8*(gi % 4) +: 6] : shadow_q[gi];
      assign active_d[gi] = grp_en[gi / PADS_PER_STEP] ? shadow_q[gi] : active_q[gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '{default: '0};
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  pad_cfg_commit_seq #(
    .NUM_STEPS (NUM_STEPS)
  ) u_seq (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (commit_start),
    .grp_en_o (grp_en),
    .busy_o   (busy),
    .done_o   (commit_done_o)
  );

  assign pad_cfg_o     = active_q;
  assign busy_o        = busy;
  assign unused_pwdata = ^pwdata_i;

endmodule

// File: tb/tb_pad_cfg_regs.sv
// Randomized self-checking bench for pad_cfg_regs against a pad-array reference model.
module tb_pad_cfg_regs;

  localparam int NUM_PADS = 48;
  localparam int PPS      = 8;
  localparam int S        = NUM_PADS / PPS;
  localparam int NW       = NUM_PADS / 4;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b1;
  logic                     psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [11:0]              paddr_i = '0;
  logic [31:0]              pwdata_i = '0;
  logic [31:0]              prdata_o;
  logic                     pready_o, pslverr_o, busy_o, commit_done_o;
  logic [NUM_PADS-1:0][5:0] pad_cfg_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_pulses = 0;

  logic [5:0] m_shadow [NUM_PADS];
  logic [5:0] m_active [NUM_PADS];

  pad_cfg_regs #(.NUM_PADS(NUM_PADS), .PADS_PER_STEP(PPS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .pad_cfg_o(pad_cfg_o), .busy_o(busy_o), .commit_done_o(commit_done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) if (commit_done_o === 1'b1) done_pulses <= done_pulses + 1;

  function automatic logic [31:0] model_word(input int w);
    return {2'b00, m_shadow[4*w+3], 2'b00, m_shadow[4*w+2],
            2'b00, m_shadow[4*w+1], 2'b00, m_shadow[4*w]};
  endfunction

  function automatic logic [NUM_PADS*6-1:0] active_vec();
    logic [NUM_PADS*6-1:0] v;
    for (int p = 0; p < NUM_PADS; p++) v[p*6 +: 6] = m_active[p];
    return v;
  endfunction

  function automatic void model_write(input logic [11:0] addr, input logic [31:0] data);
    if (addr[1:0] == 2'b00 && addr < 12'h030)
      for (int b = 0; b < 4; b++) m_shadow[4*int'(addr[11:2]) + b] = data[8*b +: 6];
  endfunction

  function automatic void model_clear();
    for (int p = 0; p < NUM_PADS; p++) begin
      m_shadow[p] = '0;
      m_active[p] = '0;
    end
  endfunction

  // Entered and left just after a rising edge; setup phase, then access until pready.
  task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int done_cyc);
    int waits = 0;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = wdata;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (pready_o === 1'b1 || waits > 100) break;
      waits++;
    end
    vectors++;
    if (pready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL apb_timeout: addr %h pready %b after %0d waits, required 1", addr, pready_o, waits);
    end
    rdata = prdata_o; err = pslverr_o; done_cyc = cyc;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int dc;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if (pad_cfg_o !== '0 || busy_o !== 1'b0 || commit_done_o !== 1'b0 ||
        pready_o !== 1'b0 || pslverr_o !== 1'b0 || prdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: pad %h busy %b done %b rdy %b err %b rd %h, required all 0",
               pad_cfg_o, busy_o, commit_done_o, pready_o, pslverr_o, prdata_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_clear();
    for (int a = 0; a <= 12'h030; a += 4) begin
      apb(1'b0, 12'(a), 32'h0, rd, er, dc);
      vectors++;
      if (rd !== 32'h0 || er !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_read %h: got rd %h err %b, required 0 0", a, rd, er);
      end
    end
  endtask

  task automatic test_commit();
    logic [31:0] rd, d; logic er; int dc, t;
    logic [5:0] snap [NUM_PADS];
    logic [5:0] old [NUM_PADS];
    logic [NUM_PADS*6-1:0] e;
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int w = 0; w < NW; w++) begin
        if (rnd == 0) d = (w == 0) ? 32'h3F3F3F3F : 32'h0;
        else if ($urandom_range(0, 3) == 0) continue;
        else d = $urandom;
        apb(1'b1, 12'(4*w), d, rd, er, dc);
        model_write(12'(4*w), d);
      end
      for (int i = 0; i < 3; i++) begin
        int w = $urandom_range(0, NW-1);
        apb(1'b0, 12'(4*w), 32'h0, rd, er, dc);
        vectors++;
        if (rd !== model_word(w) || er !== 1'b0) begin
          miscompares++;
          $display("FAIL shadow_read w%0d: got %h err %b, required %h 0", w, rd, er, model_word(w));
        end
      end
      snap = m_shadow; old = m_active;
      apb(1'b1, 12'h030, ($urandom & 32'hFFFF_FFFA) | 32'h1, rd, er, t);
      vectors++;
      if (er !== 1'b0) begin
        miscompares++;
        $display("FAIL commit_err: got %b, required 0", er);
      end
      for (int c = 1; c <= S + 2; c++) begin
        @(negedge clk_i);
        for (int p = 0; p < NUM_PADS; p++) e[p*6 +: 6] = (c >= 2 + p / PPS) ? snap[p] : old[p];
        vectors++;
        if (pad_cfg_o !== e || busy_o !== (c <= S) || commit_done_o !== (c == S + 1)) begin
          miscompares++;
          $display("FAIL commit_T+%0d: pad %h busy %b done %b, required pad %h busy %b done %b",
                   c, pad_cfg_o, busy_o, commit_done_o, e, c <= S, c == S + 1);
        end
        @(posedge clk_i); #1;
      end
      m_active = snap;
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int dc;
    logic [11:0] bad [6] = '{12'h034, 12'h002, 12'h031, 12'h0FC, 12'h800, 12'h02E};
    for (int i = 0; i < 6; i++) begin
      for (int wr = 1; wr >= 0; wr--) begin
        apb(wr[0], bad[i], $urandom, rd, er, dc);
        vectors++;
        if (er !== 1'b1 || rd !== 32'h0) begin
          miscompares++;
          $display("FAIL bad_addr %h wr%0d: got err %b rd %h, required 1 0", bad[i], wr, er, rd);
        end
      end
    end
    for (int w = 0; w < NW; w++) begin
      apb(1'b0, 12'(4*w), 32'h0, rd, er, dc);
      vectors++;
      if (rd !== model_word(w)) begin
        miscompares++;
        $display("FAIL shadow_after_err w%0d: got %h, required %h", w, rd, model_word(w));
      end
    end
    apb(1'b1, 12'h030, $urandom & 32'hFFFF_FFFA, rd, er, dc);
    @(negedge clk_i);
    vectors++;
    if (er !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ctrl_no_commit: got err %b busy %b, required 0 0", er, busy_o);
    end
    @(posedge clk_i); #1;
    apb(1'b0, 12'h030, 32'h0, rd, er, dc);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL ctrl_idle_read: got %h err %b, required 0 0", rd, er);
    end
  endtask

  task automatic test_read_during_commit();
    logic [31:0] rd; logic er; int dc, t, d0, w;
    logic [5:0] snap [NUM_PADS];
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d = $urandom;
      w = $urandom_range(0, NW-1);
      apb(1'b1, 12'(4*w), d, rd, er, dc);
      model_write(12'(4*w), d);
    end
    snap = m_shadow; d0 = done_pulses;
    apb(1'b1, 12'h030, 32'h1, rd, er, t);
    @(posedge clk_i); #1;
    apb(1'b0, 12'h030, 32'h0, rd, er, dc);
    vectors++;
    if (rd !== 32'h2 || er !== 1'b0 || dc !== t + 3) begin
      miscompares++;
      $display("FAIL busy_read: got %h err %b cyc T+%0d, required 2 0 T+3", rd, er, dc - t);
    end
    w = $urandom_range(0, NW-1);
    apb(1'b0, 12'(4*w), 32'h0, rd, er, dc);
    vectors++;
    if (rd !== model_word(w) || dc !== t + 5) begin
      miscompares++;
      $display("FAIL busy_shadow_read w%0d: got %h cyc T+%0d, required %h T+5", w, rd, dc - t, model_word(w));
    end
    apb(1'b0, 12'h030, 32'h0, rd, er, dc);
    vectors++;
    if (rd !== 32'h0 || dc !== t + S + 1) begin
      miscompares++;
      $display("FAIL read_at_done: got %h cyc T+%0d, required 0 T+%0d", rd, dc - t, S + 1);
    end
    m_active = snap;
    vectors++;
    if (pad_cfg_o !== active_vec() || done_pulses !== d0 + 1) begin
      miscompares++;
      $display("FAIL read_commit_result: pad %h pulses %0d, required %h %0d",
               pad_cfg_o, done_pulses - d0, active_vec(), 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int dc, dc2, t, waits;
    for (int w = 0; w < NW; w++) begin
      apb(1'b1, 12'(4*w), 32'h15151515, rd, er, dc);
      model_write(12'(4*w), 32'h15151515);
    end
    apb(1'b1, 12'h030, 32'h1, rd, er, t);
    apb(1'b1, 12'h02C, 32'h2A2A2A2A, rd, er, dc);
    vectors++;
    if (dc !== t + S + 1 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL stalled_write: done cyc T+%0d err %b, required T+%0d 0", dc - t, er, S + 1);
    end
    m_active = m_shadow;
    vectors++;
    if (pad_cfg_o !== active_vec()) begin
      miscompares++;
      $display("FAIL stall_active: got %h, required %h", pad_cfg_o, active_vec());
    end
    model_write(12'h02C, 32'h2A2A2A2A);
    apb(1'b1, 12'h030, 32'h1, rd, er, dc2);
    vectors++;
    if (dc2 !== dc + 2 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL second_commit: cyc +%0d err %b, required +2 0", dc2 - dc, er);
    end
    waits = 0;
    do begin
      @(negedge clk_i);
      waits++;
    end while (busy_o === 1'b1 && waits < 50);
    @(posedge clk_i); #1;
    m_active = m_shadow;
    vectors++;
    if (pad_cfg_o !== active_vec() || waits !== S + 1) begin
      miscompares++;
      $display("FAIL b2b_active: got %h after %0d cycles, required %h after %0d",
               pad_cfg_o, waits, active_vec(), S + 1);
    end
    apb(1'b0, 12'h02C, 32'h0, rd, er, dc);
    vectors++;
    if (rd !== 32'h2A2A2A2A) begin
      miscompares++;
      $display("FAIL b2b_shadow: got %h, required 2a2a2a2a", rd);
    end
  endtask

  task automatic test_reset_mid_commit();
    logic [31:0] rd; logic er; int dc, t, d0;
    for (int w = 0; w < NW; w += 3) begin
      logic [31:0] d = $urandom | 32'h01010101;
      apb(1'b1, 12'(4*w), d, rd, er, dc);
      model_write(12'(4*w), d);
    end
    d0 = done_pulses;
    apb(1'b1, 12'h030, 32'h1, rd, er, t);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_clear();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      vectors++;
      if (pad_cfg_o !== '0 || busy_o !== 1'b0 || commit_done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset +%0d: pad %h busy %b done %b, required 0 0 0",
                 c, pad_cfg_o, busy_o, commit_done_o);
      end
      @(posedge clk_i); #1;
    end
    apb(1'b0, 12'h000, 32'h0, rd, er, dc);
    vectors++;
    if (rd !== 32'h0 || done_pulses !== d0) begin
      miscompares++;
      $display("FAIL mid_reset_after: rd %h pulses %0d, required 0 0", rd, done_pulses - d0);
    end
  endtask

  task automatic test_lock();
    logic [31:0] rd, d; logic er; int dc;
    d = $urandom;
    apb(1'b1, 12'h004, d, rd, er, dc);
    model_write(12'h004, d);
    apb(1'b1, 12'h030, 32'h4, rd, er, dc);
    vectors++;
    if (er !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_set_err: got %b, required 0", er);
    end
`ifdef PAD_CFG_LOCK_EN
    apb(1'b1, 12'h004, 32'h01, rd, er, dc);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL locked_write_err: got %b, required 1", er);
    end
    apb(1'b1, 12'h030, 32'h1, rd, er, dc);
    @(negedge clk_i);
    vectors++;
    if (er !== 1'b1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL locked_commit: err %b busy %b, required 1 0", er, busy_o);
    end
    @(posedge clk_i); #1;
    apb(1'b0, 12'h030, 32'h0, rd, er, dc);
    vectors++;
    if (rd !== 32'h4) begin
      miscompares++;
      $display("FAIL lock_ctrl_read: got %h, required 4", rd);
    end
`else
    apb(1'b1, 12'h004, 32'h01, rd, er, dc);
    model_write(12'h004, 32'h01);
    vectors++;
    if (er !== 1'b0) begin
      miscompares++;
      $display("FAIL unlocked_write_err: got %b, required 0", er);
    end
    apb(1'b0, 12'h030, 32'h0, rd, er, dc);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL nolock_ctrl_read: got %h, required 0", rd);
    end
`endif
    apb(1'b0, 12'h004, 32'h0, rd, er, dc);
    vectors++;
    if (rd !== model_word(1) || er !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_shadow_read: got %h err %b, required %h 0", rd, er, model_word(1));
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_errors();
    test_read_during_commit();
    test_back_to_back();
    test_reset_mid_commit();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
